// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single SRAM read/write port between
// instruction fetch and the data-memory stage. Data wins by default.
// A saturating starvation counter guarantees fetch a grant after
// STARVE_LIMIT consecutive denied cycles.
//
// resp state | meaning
// -----------+--------------------------------------------------
// NONE       | no access last cycle, nothing to acknowledge
// IF         | fetch read issued last cycle, data on sram_dout
// DM_RD      | load issued last cycle, data on sram_dout
// DM_WR      | store committed last cycle, acknowledge only
module mem_port_arbiter #(
  parameter int SRAM_AW      = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  input  logic               if_flush,
  output logic               if_stall,
  output logic               if_valid,
  output logic [31:0]        if_rdata,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [3:0]         dm_wmask,
  input  logic [31:0]        dm_addr,
  input  logic [31:0]        dm_wdata,
  output logic               dm_stall,
  output logic               dm_valid,
  output logic [31:0]        dm_rdata,
  output logic               sram_csb,
  output logic               sram_web,
  output logic [3:0]         sram_wmask,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_din,
  input  logic [31:0]        sram_dout
);

  localparam logic [1:0] RESP_NONE  = 2'd0;
  localparam logic [1:0] RESP_IF    = 2'd1;
  localparam logic [1:0] RESP_DM_RD = 2'd2;
  localparam logic [1:0] RESP_DM_WR = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] resp;
  logic       kill;
  logic [3:0] starve_cnt;
  logic       grant_if;
  logic       grant_dm;
  logic       if_priority;

  // Address bits outside the word index are intentionally dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:SRAM_AW+2],
                              dm_addr[1:0], dm_addr[31:SRAM_AW+2]};

  // Grant selection: data first, fetch only when alone or starved.
  always_comb begin
    if_priority = (starve_cnt == LIMIT);
    grant_if    = !rst && if_req && (!dm_req || if_priority);
    grant_dm    = !rst && dm_req && !(if_req && if_priority);
  end

  // Drive the SRAM port from whichever requester holds the grant.
  always_comb begin
    sram_csb   = !(grant_if || grant_dm);
    sram_web   = !(grant_dm && dm_we);
    sram_addr  = grant_dm ? dm_addr[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];
    sram_wmask = (grant_dm && dm_we) ? dm_wmask : 4'hF;
    sram_din   = dm_wdata;
  end

  // Stalls and response-cycle outputs.
  always_comb begin
    if_stall = if_req && !grant_if;
    dm_stall = dm_req && !grant_dm;
    if_valid = (resp == RESP_IF) && !kill && !if_flush;
    dm_valid = (resp == RESP_DM_RD) || (resp == RESP_DM_WR);
    if_rdata = sram_dout;
    dm_rdata = sram_dout;
  end

  // Record who owns next cycle's read data; a fetch issued under flush is
  // marked dead so its data is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp <= RESP_NONE;
      kill <= 1'b0;
    end else begin
      if (grant_if)
        resp <= RESP_IF;
      else if (grant_dm)
        resp <= dm_we ? RESP_DM_WR : RESP_DM_RD;
      else
        resp <= RESP_NONE;
      kill <= grant_if && if_flush;
    end
  end

  // Count consecutive cycles fetch waits behind data; saturate at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_dm && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 9;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_stall, if_valid;
  logic [31:0]   if_addr, if_rdata;
  logic          dm_req, dm_we, dm_stall, dm_valid;
  logic [3:0]    dm_wmask;
  logic [31:0]   dm_addr, dm_wdata, dm_rdata;
  logic          sram_csb, sram_web;
  logic [3:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din, sram_dout;

  mem_port_arbiter #(.SRAM_AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_stall(if_stall), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wmask(dm_wmask), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_stall(dm_stall), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: how many cycles fetch has been waiting, and which
  // responses are owed next cycle.
  int denied  = 0;
  bit pend_if = 0;
  bit pend_dm = 0;
  bit pend_ld = 0;
  bit exp_gif, exp_gdm;
  logic seen_if_stall, seen_if_valid, seen_dm_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cycle(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                       input logic dr, input logic we, input logic [3:0] wm,
                       input logic [31:0] da, input logic [31:0] wd, input logic [31:0] dout);
    rst = r; if_req = ir; if_addr = ia; if_flush = fl;
    dm_req = dr; dm_we = we; dm_wmask = wm; dm_addr = da; dm_wdata = wd;
    sram_dout = dout;
    exp_gif = !r && ir && (!dr || denied >= LIM);
    exp_gdm = !r && dr && !exp_gif;
    #3;
    seen_if_stall = if_stall;
    seen_if_valid = if_valid;
    seen_dm_valid = dm_valid;
    chk("sram_csb", sram_csb, !(exp_gif || exp_gdm));
    chk("sram_web", sram_web, !(exp_gdm && we));
    chk("if_stall", if_stall, ir && !exp_gif);
    chk("dm_stall", dm_stall, dr && !exp_gdm);
    if (exp_gif) begin
      chk("addr_if", sram_addr, (ia >> 2) % (1 << AW));
      chk("wmask_if", sram_wmask, 4'hF);
    end
    if (exp_gdm) begin
      chk("addr_dm", sram_addr, (da >> 2) % (1 << AW));
      chk("wmask_dm", sram_wmask, we ? wm : 4'hF);
      if (we) chk("din", sram_din, wd);
    end
    chk("if_valid", if_valid, pend_if && !fl);
    chk("dm_valid", dm_valid, pend_dm);
    if (pend_if && !fl) chk("if_rdata", if_rdata, dout);
    if (pend_ld) chk("dm_rdata", dm_rdata, dout);
    @(posedge clk);
    pend_if = exp_gif && !fl;
    pend_dm = exp_gdm;
    pend_ld = exp_gdm && !we;
    if (r || !ir || exp_gif) denied = 0;
    else denied++;
    #1;
  endtask

  task automatic idle(input logic [31:0] dout);
    cycle(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, dout);
  endtask

  initial begin
    rst = 1; if_req = 1; dm_req = 1; if_flush = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_wmask = 0; sram_dout = 0;
    @(posedge clk); #1;

    // Reset held with both requesting: stalls high, no selects, no valids.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 32'h20, 0, 1, 0, 4'hF, 32'h40, 0, 32'h1);
      chk("reset_if_stall", seen_if_stall, 1'b1);
    end
    // First cycle out of reset grants data.
    cycle(0, 1, 32'h20, 0, 1, 0, 4'hF, 32'h40, 0, 32'h2);
    idle(32'h0000_00AA);
    idle(32'h0);

    // Single fetch, then its data.
    cycle(0, 1, 32'h0000_0010, 0, 0, 0, 4'h0, 0, 0, 32'h0);
    idle(32'h0000_0013);
    chk("fetch_valid", seen_if_valid, 1'b1);

    // Store, then acknowledge.
    cycle(0, 0, 0, 0, 1, 1, 4'b0011, 32'h0000_0104, 32'hDEADBEEF, 32'h0);
    idle(32'h5555_5555);
    chk("store_ack", seen_dm_valid, 1'b1);

    // Contention: fetch wins on cycles 5 and 10 only.
    for (int i = 1; i <= 12; i++) begin
      cycle(0, 1, 32'h100 + 32'(4 * i), 0, 1, 0, 4'hF, 32'h200 + 32'(4 * i), 0, 32'(i));
      chk("contention_if_stall", seen_if_stall, !(i == 5 || i == 10));
    end
    idle(32'h77);
    idle(32'h0);

    // Flush arriving in the response cycle.
    cycle(0, 1, 32'h30, 0, 0, 0, 4'h0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 0, 0, 4'h0, 0, 0, 32'h99);
    chk("flush_resp", seen_if_valid, 1'b0);
    // Flush in the grant cycle kills the later response.
    cycle(0, 1, 32'h30, 1, 0, 0, 4'h0, 0, 0, 32'h0);
    idle(32'h98);
    chk("flush_grant", seen_if_valid, 1'b0);

    // Back-to-back: load then fetch.
    cycle(0, 0, 0, 0, 1, 0, 4'h0, 32'h0000_0080, 0, 32'h0);
    cycle(0, 1, 32'h0000_0044, 0, 0, 0, 4'h0, 0, 0, 32'hCAFE_0001);
    chk("b2b_dm_valid", seen_dm_valid, 1'b1);
    chk("b2b_if_idle", seen_if_valid, 1'b0);
    idle(32'hCAFE_0002);
    chk("b2b_if_valid", seen_if_valid, 1'b1);
    chk("b2b_dm_idle", seen_dm_valid, 1'b0);

    // Reset asserted with requests pending: nothing is acknowledged after.
    cycle(1, 1, 32'h8, 0, 1, 1, 4'hF, 32'hC, 32'h1, 32'h0);
    idle(32'h0);
    chk("reset_mid_dm", seen_dm_valid, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(0, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
            $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single read/write port of the unified SKY130 SRAM macro between the instruction-fetch stage and the data-memory stage of the 5-stage RISC-V core. It issues at most one SRAM access per cycle, routes the one-cycle-latency read data back to the requester that owns it, and returns per-port stall signals to the pipeline stall/flush logic. Data accesses win by default. A bounded starvation counter guarantees forward progress for instruction fetch.

## Interface
- `SRAM_AW`, default 9: SRAM word-address width (512 x 32b).
- `STARVE_LIMIT`, default 4: consecutive denied fetch cycles after which fetch gets priority for one grant; legal range 1-15.

- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, level; held until granted.
- `if_addr` in 32: fetch byte address.
- `if_flush` in 1: kill any in-flight fetch (from pipeline flush).
- `if_stall` out 1: fetch request present but not granted this cycle.
- `if_valid` out 1: fetch read data valid this cycle.
- `if_rdata` out 32: fetch read data.
- `dm_req` in 1: data request, level; held until granted.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_wmask` in 4: byte-write enables for stores.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: store data.
- `dm_stall` out 1: data request present but not granted this cycle.
- `dm_valid` out 1: load data valid, or store acknowledged, this cycle.
- `dm_rdata` out 32: load data.
- `sram_csb` out 1: chip select, active-low.
- `sram_web` out 1: write enable, active-low.
- `sram_wmask` out 4: byte mask to SRAM.
- `sram_addr` out SRAM_AW: word address = `addr[SRAM_AW+1:2]`.
- `sram_din` out 32: SRAM write data.
- `sram_dout` in 32: SRAM read data, valid one cycle after the access.

## Operation
**Grant selection** is combinational each cycle; `grant_if` and `grant_dm` are one-hot or both zero:
- If only one request is present, that request is granted.
- If both are present, `dm` is granted, unless `starve_cnt == STARVE_LIMIT`, in which case `if` is granted.
- No grants are issued while `rst` is high.

**SRAM drive on a grant:**
- `sram_csb` = 0.
- `sram_web` = !(grant_dm && dm_we).
- Address, mask and data are muxed from the granted port.
- `sram_wmask` = 4'hF for fetch and for loads.
- With no grant: `sram_csb` = 1, `sram_web` = 1, and the other SRAM outputs are don't-care.
- Address bits `[1:0]` are ignored. Bits above `SRAM_AW+1` are ignored (the address aliases).

**Stall outputs:** `if_stall` = if_req && !grant_if and `dm_stall` = dm_req && !grant_dm, both combinational. During reset, stall = req.

**Response owner register `resp`**, with states NONE / IF / DM_RD / DM_WR, is loaded every cycle from the current grant:
- IF on `grant_if`.
- DM_RD on a load grant.
- DM_WR on a store grant.
- NONE otherwise.

**Kill flag:** set when `resp` is loaded with IF while `if_flush` is high. Clear it on every other load of `resp`.

**Response cycle** (the cycle after the grant):
- `if_valid` = (resp == IF) && !kill && !if_flush.
- `dm_valid` = (resp == DM_RD) || (resp == DM_WR).
- `if_rdata` and `dm_rdata` = sram_dout. They are meaningful only while the matching valid is high.

**Starvation counter `starve_cnt`** (4 bits):
- Clears on `grant_if` or when `if_req` = 0.
- Increments when if_req && grant_dm.
- Saturates at STARVE_LIMIT.

## Timing
- Reset values:
  - `resp` = NONE, `kill` = 0, `starve_cnt` = 0.
  - `if_valid` = 0, `dm_valid` = 0.
  - `sram_csb` = 1, `sram_web` = 1.
- Reset mid-operation: an access granted in the cycle that `rst` asserts is never acknowledged. Valids are 0 in the cycle after reset.
- Latency: grant in cycle N gives the matching valid in cycle N+1. Throughput is 1 access/cycle; back-to-back grants to the same or alternating ports are legal.
- A requester may change address or data only after the cycle in which its stall is low with its request high.
- A store is committed at the grant edge. `dm_valid` in N+1 is only an acknowledgment.
- With both ports requesting continuously, fetch is granted once every STARVE_LIMIT+1 cycles.
- `if_flush` suppresses the current response-cycle `if_valid` and any response issued under flush. It does not cancel the SRAM access and does not affect `dm`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `if_req` = `dm_req` = 1. Required: `sram_csb` = 1, `if_stall` = `dm_stall` = 1, no valids. First grant occurs in the first cycle with `rst` low.
- **Single fetch:** `if_req` with `if_addr` = 0x0000_0010 in cycle N. Required: `sram_addr` = 4, `sram_csb` = 0, `sram_web` = 1. In N+1 with `sram_dout` = 0x0000_0013: `if_valid` = 1 and `if_rdata` = 0x0000_0013.
- **Store:** `dm_we` = 1, `dm_addr` = 0x0000_0104, `dm_wmask` = 4'b0011, `dm_wdata` = 0xDEADBEEF. Required: `sram_addr` = 0x41, `sram_web` = 0, mask 0011, `dm_valid` = 1 in N+1.
- **Contention:** both requesting for 12 cycles with STARVE_LIMIT = 4. Required: grant pattern dm,dm,dm,dm,if repeating. `if_stall` is low exactly on cycles 5 and 10.
- **Flush:** grant a fetch in N with `if_flush` = 1 in N+1. Required: `if_valid` = 0 in N+1. Repeat the fetch with `if_flush` = 1 in N, low in N+1. Required: `if_valid` = 0 in N+1.
- **Back-to-back:** load in N, fetch in N+1. Required: `dm_valid` = 1 only in N+1, `if_valid` = 1 only in N+2, with rdata matching the respective `sram_dout`.
